// File: rtl/core_sequencer.sv
// Run controller around the 9-bit-ISA core. It holds the core in reset, releases it,
// and counts execution cycles until the core halts or the cycle budget runs out.
module core_sequencer #(
    parameter int RST_CYCLES = 4,
    parameter int CW         = 16,
    parameter int MAX_CYCLES = 5000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          core_reset,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_count,
    output logic [7:0]    run_id
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] BUDGET     = CW'(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          core_reset_n;
    logic          busy_n;
    logic          finished_n;
    logic          timed_out_n;
    logic [CW-1:0] cycle_count_n;
    logic [7:0]    run_id_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            hold_cnt    <= '0;
            core_reset  <= 1'b1;
            busy        <= 1'b0;
            finished    <= 1'b0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
            run_id      <= '0;
        end else begin
            state       <= state_n;
            hold_cnt    <= hold_cnt_n;
            core_reset  <= core_reset_n;
            busy        <= busy_n;
            finished    <= finished_n;
            timed_out   <= timed_out_n;
            cycle_count <= cycle_count_n;
            run_id      <= run_id_n;
        end
    end

    always_comb begin
        state_n       = state;
        hold_cnt_n    = hold_cnt;
        core_reset_n  = core_reset;
        finished_n    = finished;
        timed_out_n   = timed_out;
        cycle_count_n = cycle_count;
        run_id_n      = run_id;

        case (state)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                // An idle core is always held in reset; a halted core is left
                // running-but-halted so its state can be inspected.
                if (state == S_IDLE) begin
                    core_reset_n = 1'b1;
                end
                if (start) begin
                    state_n       = S_HOLD;
                    hold_cnt_n    = '0;
                    core_reset_n  = 1'b1;
                    finished_n    = 1'b0;
                    timed_out_n   = 1'b0;
                    cycle_count_n = '0;
                end
            end

            S_HOLD: begin
                hold_cnt_n = hold_cnt + HW'(1);
                if (hold_cnt == HOLD_LAST) begin
                    state_n      = S_RUN;
                    core_reset_n = 1'b0;
                end
            end

            S_RUN: begin
                // Halt takes priority over budget exhaustion in the same cycle.
                if (core_done) begin
                    state_n    = S_DONE;
                    finished_n = 1'b1;
                    run_id_n   = run_id + 8'd1;
                end else begin
                    if (cycle_count == LAST_CYCLE) begin
                        state_n       = S_TIMEOUT;
                        cycle_count_n = BUDGET;
                        timed_out_n   = 1'b1;
                        core_reset_n  = 1'b1;
                    end else begin
                        cycle_count_n = cycle_count + CW'(1);
                    end
                end
            end

            default: begin
                state_n      = S_IDLE;
                core_reset_n = 1'b1;
            end
        endcase

        busy_n = (state_n == S_HOLD) || (state_n == S_RUN);
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Randomized scoreboard bench for core_sequencer: a behavioural core stand-in drives
// core_done, and each run's expected outcome is queued for an independent monitor.
module tb_core_sequencer;

    localparam int RST = 4;
    localparam int CW  = 16;
    localparam int MAX = 50;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_done;
    logic          core_reset;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycle_count;
    logic [7:0]    run_id;

    core_sequencer #(.RST_CYCLES(RST), .CW(CW), .MAX_CYCLES(MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_done  (core_done),
        .core_reset (core_reset),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .cycle_count(cycle_count),
        .run_id     (run_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit      fin;
        bit      tmo;
        int      cnt;
        int      rid;
        bit      crst;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   completed = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference outcome of one run from the rules: halt at RUN cycle k inside the budget
    // completes with count k, otherwise the run times out at the full budget.
    task automatic push_expect(input int k);
        exp_t e;
        if (k < MAX) begin
            completed++;
            e.fin = 1; e.tmo = 0; e.cnt = k;   e.crst = 0;
        end else begin
            e.fin = 0; e.tmo = 1; e.cnt = MAX; e.crst = 1;
        end
        e.rid = completed % 256;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed run (busy falling outside reset) is checked against the queue.
    bit prev_busy = 0;
    int hold_seen = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 0;
            hold_seen = 0;
        end else begin
            if (busy && core_reset) hold_seen++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_run_end", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("finished",    finished,    e.fin);
                    check("timed_out",   timed_out,   e.tmo);
                    check("cycle_count", cycle_count, e.cnt);
                    check("run_id",      run_id,      e.rid);
                    check("core_reset",  core_reset,  e.crst);
                    check("hold_cycles", hold_seen,   RST);
                end
                hold_seen = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic do_run(input int k, input bit poke);
        int n;
        push_expect(k);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",     busy,        1);
        check("start_coreRst",  core_reset,  1);
        check("start_clr_fin",  finished,    0);
        check("start_clr_tmo",  timed_out,   0);
        check("start_clr_cnt",  cycle_count, 0);
        n = 0;
        while (core_reset && n < RST + 5) begin
            core_done = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (core_reset) check("release_timeout", 1, 0);
        n = 0;
        while (busy && n < MAX + 10) begin
            core_done = (n == k);
            start     = poke && ((n == k) || ($urandom_range(0, 3) == 0));
            @(negedge clk);
            n++;
        end
        if (busy) check("run_end_timeout", 1, 0);
        core_done = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got %0d runs, expected more", completed);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; core_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_coreRst", core_reset,  1);
        check("rst_busy",    busy,        0);
        check("rst_fin",     finished,    0);
        check("rst_tmo",     timed_out,   0);
        check("rst_cnt",     cycle_count, 0);
        check("rst_rid",     run_id,      0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_coreRst", core_reset, 1);

        do_run(37, 0);
        do_run(1000, 0);
        do_run(MAX - 1, 1);
        do_run(0, 1);

        // Asynchronous reset in the middle of HOLD, sampled before the next edge.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_coreRst", core_reset,  1);
        check("async_busy",    busy,        0);
        check("async_fin",     finished,    0);
        check("async_rid",     run_id,      0);
        check("async_cnt",     cycle_count, 0);
        completed = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 20; r++) do_run($urandom_range(0, MAX + 10), 1'($urandom_range(0, 1)));
        while (completed < 258) do_run($urandom_range(0, 3), 1'($urandom_range(0, 1)));

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Run controller that wraps the 9-bit-ISA core top level and owns its `reset` and `done` lines. On a `start` pulse it holds the core in reset for a fixed number of cycles, releases it, and counts execution cycles until the core's `done` (Halt) rises or a cycle budget expires. It then reports the cycle count, a completion or timeout flag and a run index. It is the stage directly around the core: its `core_reset` drives the core's `reset`, and it consumes the core's `done`.

## Interface
Parameters:
- `RST_CYCLES`, default 4: number of cycles `core_reset` is held high per run; must be ≥1.
- `CW`, default 16: width of the cycle counter.
- `MAX_CYCLES`, default 5000: cycle budget per run; must satisfy 1 ≤ `MAX_CYCLES` ≤ 2^CW−1.

Ports:
- `clk` in 1: single clock, shared with the core.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to begin a run.
- `core_done` in 1: the core's `done` output.
- `core_reset` out 1: drives the core's `reset`; registered.
- `busy` out 1: high in HOLD and RUN.
- `finished` out 1: high in DONE (sticky until the next accepted start).
- `timed_out` out 1: high in TIMEOUT (sticky until the next accepted start).
- `cycle_count` out CW: number of RUN cycles elapsed.
- `run_id` out 8: count of runs that completed successfully.

## Operation
States: IDLE, HOLD, RUN, DONE, TIMEOUT. All outputs are registered.

Reset values (applied asynchronously): state=IDLE, `core_reset`=1, `busy`=0, `finished`=0, `timed_out`=0, `cycle_count`=0, `run_id`=0, hold counter=0.

Transitions:
- **IDLE, DONE or TIMEOUT, with `start`=1** → HOLD. On this transition: `cycle_count`←0, `finished`←0, `timed_out`←0, `core_reset`←1, hold counter←0.
- **HOLD**: the hold counter increments each cycle. When it equals `RST_CYCLES`−1 → RUN, and `core_reset`←0 on that edge.
- **RUN, with `core_done`=1** → DONE. `cycle_count` is frozen, `finished`←1, `run_id`←`run_id`+1 (wraps 255→0). `core_reset` stays 0 so the halted core keeps its state for inspection.
- **RUN, with `core_done`=0**: `cycle_count` increments. If the pre-increment value equals `MAX_CYCLES`−1 → TIMEOUT, with `cycle_count`=`MAX_CYCLES`, `timed_out`←1 and `core_reset`←1.
- **`start` in HOLD or RUN** is ignored. There is no queueing.
- **IDLE**: `core_reset` stays 1. The core is never running unsupervised.

Boundary rules:
- `core_done` and budget exhaustion in the same RUN cycle: DONE wins; the count is not incremented.
- `start` in the same cycle that RUN sees `core_done`: `start` is ignored and the state goes to DONE.
- `core_done` is ignored outside RUN. The core forces `done` low while in reset anyway.
- `reset` mid-run returns to IDLE immediately, with `core_reset`=1 asynchronously. The core is reset with it.
- `cycle_count` never exceeds `MAX_CYCLES` and never wraps.

## Timing
- `start` sampled high at edge t: `busy` and `core_reset` are high from t, and `core_reset` stays high for exactly `RST_CYCLES` cycles.
- `core_reset` falls at edge t+`RST_CYCLES`, and RUN begins on that edge.
- The core's first instruction executes in the cycle after that edge, which is RUN cycle 0. `cycle_count` reads 0 during that cycle.
- If the core asserts `done` during RUN cycle k, DONE is entered at the next edge with `cycle_count`=k and `finished`=1 (1-cycle latency).
- Timeout: if `done` never asserts, TIMEOUT is entered at the end of RUN cycle `MAX_CYCLES`−1.
- `core_done` is used as sampled at the edge, with no synchronizer, since it shares `clk`.

## Test plan
- **Reset**: assert `reset` mid-HOLD → all outputs return to reset values in the same cycle, with `core_reset`=1.
- **Normal run**: `RST_CYCLES`=4; `start` at t; `core_done` rises in RUN cycle 37 → `core_reset` is high for 4 cycles; then `finished`=1, `cycle_count`=37, `run_id`=1, `busy`=0.
- **Timeout**: `MAX_CYCLES`=10; `core_done` held low → `timed_out`=1, `cycle_count`=10, `core_reset`=1, `run_id` unchanged.
- **Collision**: `core_done` rises in RUN cycle `MAX_CYCLES`−1 → DONE, `cycle_count`=`MAX_CYCLES`−1, `timed_out`=0.
- **Start handling**: `start` during RUN is ignored; `start` in DONE starts a new run, clearing `finished` and `cycle_count` on the same edge; 256 completed runs wrap `run_id` to 0.
- **Full-core run**: with the core attached running the int-to-float program, the run ends in DONE, and `cycle_count` matches the cycle count from the core's reference simulation.
